// File: rtl/tnn_feature_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : tnn_feature_quantizer
//  Description : Serial raw-feature stream to per-sample vector of 2-bit codes
//                against programmable per-feature thresholds.
//  Revision    : 1.0  initial release
// ============================================================================
module tnn_feature_quantizer #(
    parameter int N_FEAT = 7,
    parameter int IN_W   = 8,
    parameter int T0_RST = 64,
    parameter int T1_RST = 128,
    parameter int T2_RST = 192
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [IN_W-1:0]               s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [2*N_FEAT-1:0]           m_feat,
    input  logic                          cfg_we,
    input  logic [$clog2(3*N_FEAT)-1:0]   cfg_addr,
    input  logic [IN_W-1:0]               cfg_data,
    output logic                          err,
    output logic [15:0]                   frame_cnt
);

    localparam int AW = $clog2(3*N_FEAT);
    localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    localparam logic [0:0] c_COLLECT = 1'b0;
    localparam logic [0:0] c_HOLD    = 1'b1;

    logic [0:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic [2*N_FEAT-1:0]  r_slots;
    logic [2*N_FEAT-1:0]  r_feat;
    logic [2*N_FEAT-1:0]  w_codes;
    logic [2*N_FEAT-1:0]  w_slots_next;
    logic [1:0]           w_code;
    logic                 w_accept;
    logic                 w_last_idx;
    logic                 r_err;
    logic [15:0]          r_frame_cnt;

    // Every feature quantizes the incoming beat in parallel; the slot index picks one.
    for (genvar f = 0; f < N_FEAT; f++) begin : g_feat
        logic [IN_W-1:0] r_t0;
        logic [IN_W-1:0] r_t1;
        logic [IN_W-1:0] r_t2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_t0 <= IN_W'(T0_RST);
                r_t1 <= IN_W'(T1_RST);
                r_t2 <= IN_W'(T2_RST);
            end else if (cfg_we) begin
                if (cfg_addr == AW'(3*f))     r_t0 <= cfg_data;
                if (cfg_addr == AW'(3*f + 1)) r_t1 <= cfg_data;
                if (cfg_addr == AW'(3*f + 2)) r_t2 <= cfg_data;
            end
        end

        assign w_codes[2*f +: 2] = {1'b0, (s_data >= r_t0)}
                                 + {1'b0, (s_data >= r_t1)}
                                 + {1'b0, (s_data >= r_t2)};
    end

    assign w_code     = w_codes[{r_idx, 1'b0} +: 2];
    assign w_last_idx = (r_idx == IW'(N_FEAT - 1));
    assign s_ready    = (r_state == c_COLLECT) && !rst;
    assign w_accept   = s_valid && s_ready;

    always_comb begin
        w_slots_next = r_slots;
        w_slots_next[{r_idx, 1'b0} +: 2] = w_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_COLLECT;
            r_idx       <= '0;
            r_slots     <= '0;
            r_feat      <= '0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_COLLECT: begin
                    if (w_accept) begin
                        if (w_last_idx && s_last) begin
                            // Only a complete frame is ever copied to the output.
                            r_feat  <= w_slots_next;
                            r_state <= c_HOLD;
                            r_idx   <= '0;
                        end else if (w_last_idx || s_last) begin
                            r_err <= 1'b1;
                            r_idx <= '0;
                        end else begin
                            r_slots <= w_slots_next;
                            r_idx   <= r_idx + IW'(1);
                        end
                    end
                end
                c_HOLD: begin
                    if (m_ready) begin
                        r_state     <= c_COLLECT;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                default: r_state <= c_COLLECT;
            endcase
        end
    end

    assign m_valid   = (r_state == c_HOLD);
    assign m_feat    = r_feat;
    assign err       = r_err;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tnn_feature_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tnn_feature_quantizer
//  Description : Self-checking bench for tnn_feature_quantizer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tnn_feature_quantizer;

    localparam int N_FEAT = 7;
    localparam int IN_W   = 8;
    localparam int AW     = $clog2(3*N_FEAT);
    localparam int FW     = 2*N_FEAT;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [IN_W-1:0] s_data = '0;
    logic            s_last = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [FW-1:0]   m_feat;
    logic            cfg_we = 1'b0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [IN_W-1:0] cfg_data = '0;
    logic            err;
    logic [15:0]     frame_cnt;

    tnn_feature_quantizer dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_feat(m_feat),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0] d [N_FEAT];
        logic [FW-1:0]   feat;
    } vec_t;

    vec_t            tbl [5];
    int              checks = 0;
    int              errors = 0;
    logic [FW-1:0]   sb_q [$];
    logic [FW-1:0]   mon_e;
    logic [15:0]     exp_cnt = '0;
    logic [IN_W-1:0] thr_m [3*N_FEAT];
    bit              rand_mr = 1'b0;
    logic            mr_force = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] q(input int f, input logic [IN_W-1:0] x);
        int s;
        s = 0;
        if (x >= thr_m[3*f])     s++;
        if (x >= thr_m[3*f + 1]) s++;
        if (x >= thr_m[3*f + 2]) s++;
        return s[1:0];
    endfunction

    task automatic thr_defaults();
        for (int i = 0; i < 3*N_FEAT; i++)
            thr_m[i] = (i % 3 == 0) ? 8'd64 : (i % 3 == 1) ? 8'd128 : 8'd192;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d, input logic last, input int gap);
        int t;
        t = 0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout actual=%0d required=1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [IN_W-1:0] d [N_FEAT], input int maxgap, input bit push);
        logic [FW-1:0] e;
        for (int i = 0; i < N_FEAT; i++) e[2*i +: 2] = q(i, d[i]);
        for (int i = 0; i < N_FEAT; i++)
            send_beat(d[i], (i == N_FEAT-1), (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
        if (push) sb_q.push_back(e);
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [IN_W-1:0] v);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = v;
        tick();
        cfg_we = 1'b0;
        if (int'(a) < 3*N_FEAT) thr_m[a] = v;
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
            sb_q.delete();
        end
        tick();
    endtask

    always @(posedge clk) begin
        #1;
        m_ready = rand_mr ? 1'($urandom_range(0, 1)) : mr_force;
    end

    // Output side of the scoreboard: every handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vector actual=%0h required=none", m_feat);
            end else begin
                mon_e = sb_q.pop_front();
                chk("m_feat", 32'(m_feat), 32'(mon_e));
                chk("frame_cnt_at_handshake", 32'(frame_cnt), 32'(exp_cnt));
            end
            exp_cnt = exp_cnt + 16'd1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0] d [N_FEAT];

        tbl[0].d = '{0, 63, 64, 127, 128, 191, 192};     tbl[0].feat = 14'b11_10_10_01_01_00_00;
        tbl[1].d = '{0, 0, 0, 0, 0, 0, 0};               tbl[1].feat = 14'b00_00_00_00_00_00_00;
        tbl[2].d = '{255, 255, 255, 255, 255, 255, 255}; tbl[2].feat = 14'b11_11_11_11_11_11_11;
        tbl[3].d = '{255, 0, 255, 0, 255, 0, 255};       tbl[3].feat = 14'b11_00_11_00_11_00_11;
        tbl[4].d = '{65, 129, 193, 1, 64, 128, 192};     tbl[4].feat = 14'b11_10_01_00_11_10_01;
        thr_defaults();

        // Reset state
        repeat (3) tick();
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_feat", 32'(m_feat), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(s_ready), 1);
        tick();

        // Table-driven vectors with defaults
        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].d, 0, 1'b0);
            sb_q.push_back(tbl[i].feat);
            if (i == 0) chk("m_valid_latency", 32'(m_valid), 1);
            wait_drain(50);
        end

        // Back-pressure in HOLD
        mr_force = 1'b0;
        tick();
        d = '{10, 70, 130, 200, 0, 0, 255};
        send_frame(d, 0, 1'b1);
        s_valid = 1'b1; s_data = 8'd5; s_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_m_feat", 32'(m_feat), 32'(14'b11_00_00_11_10_01_00));
            chk("hold_s_ready", 32'(s_ready), 0);
            chk("hold_m_valid", 32'(m_valid), 1);
        end
        s_valid = 1'b0; s_last = 1'b0;
        mr_force = 1'b1;
        wait_drain(20);
        chk("hold_frame_cnt", 32'(frame_cnt), 6);
        chk("hold_release_s_ready", 32'(s_ready), 1);

        // Early s_last
        for (int i = 0; i < 4; i++) send_beat(8'(i * 60), (i == 3), 0);
        chk("early_last_err", 32'(err), 1);
        chk("early_last_m_valid", 32'(m_valid), 0);
        tick();
        chk("early_last_err_pulse", 32'(err), 0);
        d = '{200, 150, 100, 50, 0, 255, 128};
        send_frame(d, 0, 1'b1);
        wait_drain(20);
        // Missing s_last
        for (int i = 0; i < N_FEAT; i++) send_beat(8'd250, 1'b0, 0);
        chk("no_last_err", 32'(err), 1);
        chk("no_last_m_valid", 32'(m_valid), 0);
        tick();
        chk("no_last_err_pulse", 32'(err), 0);
        chk("no_last_m_valid2", 32'(m_valid), 0);
        d = '{1, 64, 200, 130, 63, 192, 127};
        send_frame(d, 0, 1'b1);
        wait_drain(20);

        // Threshold write, then same-cycle write vs. beat
        cfg_write(0, 8'd10);
        d = '{10, 0, 0, 0, 0, 0, 0};
        send_frame(d, 0, 1'b0);
        sb_q.push_back(14'h0001);
        wait_drain(20);
        cfg_write(0, 8'd64);
        cfg_we = 1'b1; cfg_addr = 0; cfg_data = 8'd10;
        s_valid = 1'b1; s_data = 8'd10; s_last = 1'b0;
        @(negedge clk);
        chk("same_cycle_s_ready", 32'(s_ready), 1);
        tick();
        cfg_we = 1'b0; s_valid = 1'b0;
        thr_m[0] = 8'd10;
        for (int i = 1; i < N_FEAT; i++) send_beat(8'd0, (i == N_FEAT-1), 0);
        sb_q.push_back(14'h0000);
        wait_drain(20);

        // Out-of-range address, then reset mid-frame
        cfg_write(5'd21, 8'd0);
        d = '{10, 1, 1, 1, 1, 1, 1};
        send_frame(d, 0, 1'b1);
        wait_drain(20);
        for (int i = 0; i < 3; i++) send_beat(8'd255, 1'b0, 0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        thr_defaults();
        exp_cnt = '0;
        chk("midrst_frame_cnt", 32'(frame_cnt), 0);
        chk("midrst_m_valid", 32'(m_valid), 0);
        d = '{10, 63, 64, 127, 128, 191, 192};
        send_frame(d, 0, 1'b1);
        wait_drain(20);

        // Reset while holding a vector
        mr_force = 1'b0;
        tick();
        send_frame(tbl[2].d, 0, 1'b1);
        chk("hold_before_rst_m_valid", 32'(m_valid), 1);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        sb_q.delete();
        exp_cnt = '0;
        mr_force = 1'b1;
        chk("hold_rst_m_valid", 32'(m_valid), 0);
        chk("hold_rst_frame_cnt", 32'(frame_cnt), 0);
        chk("hold_rst_m_feat", 32'(m_feat), 0);
        repeat (3) tick();

        // Random frames with random gaps, back-pressure and reconfiguration
        rand_mr = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(AW'($urandom_range(0, 22)), 8'($urandom_range(0, 255)));
            for (int i = 0; i < N_FEAT; i++) d[i] = 8'($urandom_range(0, 255));
            send_frame(d, 2, 1'b1);
        end
        wait_drain(100);
        chk("random_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Counter wrap from a preloaded value
        rand_mr = 1'b0;
        mr_force = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        exp_cnt = 16'hFFFF;
        tick();
        send_frame(tbl[4].d, 0, 1'b1);
        wait_drain(20);
        chk("wrap_frame_cnt", 32'(frame_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
